// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receive deserializer: stereo sample pairs with valid/ready, frame error and overrun pulses
// Optional feature macro: I2S_RX_MONO_SUM_EN (both channels carry the mean of the pair when defined).

module i2s_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  lrck,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] sample_left,
    output logic [DATA_WIDTH-1:0] sample_right,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  frame_err,
    output logic                  overrun
);

    // Counter must hold SLOT_WIDTH itself so over-long slots saturate instead of wrapping.
    localparam int CNT_W = $clog2(SLOT_WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_DATA      = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SLOT_LAST = CNT_W'(SLOT_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_SLOT      = CNT_W'(SLOT_WIDTH);

    // Synchronizer stages and edge-detect register.
    logic sclk_s1;
    logic sclk_s2;
    logic sclk_d;
    logic lrck_s1;
    logic lrck_s2;
    logic sdata_s1;
    logic sdata_s2;

    // Framing state.
    logic [1:0]            state;
    logic                  lrck_prev;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] hold_left;
    logic                  left_ok;

    // Decoded per-cycle events.
    logic                  bit_edge;
    logic                  boundary;
    logic                  capture_edge;
    logic                  shifting;
    logic                  word_done;
    logic                  left_done;
    logic                  publish;
    logic                  slot_bad;
    logic [DATA_WIDTH-1:0] word_next;
    logic [DATA_WIDTH-1:0] pub_left;
    logic [DATA_WIDTH-1:0] pub_right;

    // Bring the three codec lines into the clock domain through two flops each.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_d   <= 1'b0;
            lrck_s1  <= 1'b0;
            lrck_s2  <= 1'b0;
            sdata_s1 <= 1'b0;
            sdata_s2 <= 1'b0;
        end else begin
            sclk_s1  <= sclk;
            sclk_s2  <= sclk_s1;
            sclk_d   <= sclk_s2;
            lrck_s1  <= lrck;
            lrck_s2  <= lrck_s1;
            sdata_s1 <= sdata;
            sdata_s2 <= sdata_s1;
        end
    end

    // Decode bit edges, slot boundaries and word completion from the synced lines.
    always_comb begin
        bit_edge     = sclk_s2 & ~sclk_d;
        boundary     = bit_edge & (lrck_s2 != lrck_prev);
        capture_edge = bit_edge & ~boundary & (state != ST_IDLE);
        shifting     = capture_edge & (bit_cnt < CNT_DATA);
        word_next    = {shift_reg[DATA_WIDTH-2:0], sdata_s2};
        word_done    = capture_edge & (bit_cnt == CNT_DATA_LAST);
        left_done    = word_done & (state == ST_LEFT);
        publish      = word_done & (state == ST_RIGHT) & left_ok;
        // The boundary edge counts as one, so a correct slot ends with bit_cnt at SLOT_WIDTH-1.
        slot_bad     = boundary & (state != ST_IDLE) & (bit_cnt != CNT_SLOT_LAST);
    end

`ifdef I2S_RX_MONO_SUM_EN
    logic [DATA_WIDTH:0]   pair_sum;
    logic [DATA_WIDTH-1:0] pair_mean;

    // Sign-extended sum of both channels halved; low bits of the shifted sum are the mean.
    always_comb begin
        pair_sum  = {hold_left[DATA_WIDTH-1], hold_left} + {word_next[DATA_WIDTH-1], word_next};
        pair_mean = DATA_WIDTH'(pair_sum >> 1);
        pub_left  = pair_mean;
        pub_right = pair_mean;
    end
`else
    // Channels pass straight through to the output registers.
    always_comb begin
        pub_left  = hold_left;
        pub_right = word_next;
    end
`endif

    // Slot tracking, bit counting, shifting and the left-word holding register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            lrck_prev <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            hold_left <= '0;
            left_ok   <= 1'b0;
        end else if (bit_edge) begin
            lrck_prev <= lrck_s2;
            if (boundary) begin
                // One-bit I2S delay: this edge's data belongs to no word.
                bit_cnt   <= '0;
                shift_reg <= '0;
                if (!lrck_s2) begin
                    state <= ST_LEFT;
                end else if (state != ST_IDLE) begin
                    state <= ST_RIGHT;
                end
                if (slot_bad) begin
                    left_ok <= 1'b0;
                end
            end else if (state != ST_IDLE) begin
                if (bit_cnt != CNT_SLOT) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (shifting) begin
                    shift_reg <= word_next;
                end
                if (left_done) begin
                    hold_left <= word_next;
                    left_ok   <= 1'b1;
                end
                if (publish) begin
                    left_ok <= 1'b0;
                end
            end
        end
    end

    // Output pair registers, valid/ready handshake and the two status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_err <= slot_bad;
            overrun   <= publish & sample_valid & ~sample_ready;
            if (publish) begin
                sample_left  <= pub_left;
                sample_right <= pub_right;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Receive-side I2S deserializer for the Pocket audio codec ADC path (`audio_adc`). It runs on the core system clock and oversamples the codec's serial clock, word select and data lines. These are the same `audgen_sclk`/`audgen_lrck` the core's DAC generator drives. It delivers stereo 16-bit sample pairs through a valid/ready handshake to core audio logic, with framing-error and overrun reporting.

## Interface
Parameters:
- `DATA_WIDTH`, 16: active bits per channel, MSB first.
- `SLOT_WIDTH`, 32: SCLK periods per channel slot; must be > `DATA_WIDTH`.

Ports:
- `clock` in 1: system clock; all logic synchronous to it; must be ≥ 4× SCLK frequency.
- `reset` in 1: asynchronous, active-high reset.
- `sclk` in 1: I2S bit clock, asynchronous to `clock`.
- `lrck` in 1: word select, asynchronous; 0 = left, 1 = right.
- `sdata` in 1: serial data (`audio_adc`), asynchronous.
- `sample_left` out `DATA_WIDTH`: left sample, two's complement.
- `sample_right` out `DATA_WIDTH`: right sample, two's complement.
- `sample_valid` out 1: pair available; held until accepted.
- `sample_ready` in 1: consumer accepts the pair when high with `sample_valid`.
- `frame_err` out 1: one-cycle pulse on a slot-length violation.
- `overrun` out 1: one-cycle pulse when an unaccepted pair is overwritten.

## Operation
- `sclk`, `lrck` and `sdata` each pass through a 2-FF synchronizer. A rising edge of synced `sclk` ("bit edge") is detected with one extra register.
- On each bit edge, synced `lrck` and `sdata` are sampled together.
- **Slot boundary:** a bit edge where sampled `lrck` differs from the previous sampled `lrck`.
  - This edge is the I2S one-bit delay; its data is discarded.
  - `bit_cnt` clears to 0 and the channel is set from the new `lrck`.
- **Data capture:** on each later bit edge, `bit_cnt` increments, saturating at `SLOT_WIDTH`.
  - While `bit_cnt` < `DATA_WIDTH` before the increment, data shifts in MSB first.
  - When the `DATA_WIDTH`th bit lands, the word is complete.
- **State machine:**
  - IDLE to LEFT on the first boundary to `lrck`=0.
  - LEFT to RIGHT on a boundary to `lrck`=1.
  - RIGHT to LEFT on a boundary to `lrck`=0.
  - IDLE ignores boundaries to `lrck`=1 and captures nothing.
- **Left word:** a completed left word is stored in a holding register and `left_ok` is set.
- **Right word:** a completed right word with `left_ok` set publishes the pair to `sample_left`/`sample_right` and clears `left_ok`.
  - A completed right word without `left_ok` is dropped.
- **Slot-length check:** at each boundary out of LEFT or RIGHT, the previous slot's edge count (boundary edge plus `bit_cnt`) must equal `SLOT_WIDTH`.
  - On a mismatch: `frame_err` pulses, `left_ok` clears, the partial word is discarded, and the state moves to LEFT or RIGHT per the new `lrck` (not to IDLE).
- **Handshake:**
  - Publishing sets `sample_valid`.
  - `sample_valid && sample_ready` clears it the following cycle.
  - If a publish arrives while `sample_valid=1` and `sample_ready=0`, the new pair overwrites, `sample_valid` stays 1 and `overrun` pulses.
  - If a publish coincides with `sample_ready=1`, the old pair is accepted, the new pair loads, `sample_valid` stays 1 and there is no overrun.

## Timing
- Reset values: `sample_left`=0, `sample_right`=0, `sample_valid`=0, `frame_err`=0, `overrun`=0. The state machine is in IDLE; `left_ok`, `bit_cnt`, the shift register and all synchronizers are 0.
- Reset asserted mid-word: everything clears immediately. Capture restarts only at the next `lrck` falling boundary.
- Bit edge detect: 3 `clock` cycles after the physical SCLK rise (2 sync + 1 edge register).
- Publish latency: `sample_valid` rises 1 `clock` after the bit edge carrying the right LSB.
- Pulse timing: `frame_err` and `overrun` are registered and assert 1 cycle after their causing bit edge or publish.
- Slot counting: `bit_cnt` saturation prevents wrap on over-long slots. A slot of `SLOT_WIDTH`+k edges still reports `frame_err`.
- Data in a slot beyond `DATA_WIDTH` bits is ignored. The bits need not be zero.

## Configuration
- `I2S_RX_MONO_SUM_EN`:
  - Defined: `sample_left` and `sample_right` both carry the arithmetic mean of the pair.
    - The mean is a sign-extended `DATA_WIDTH`+1-bit sum, arithmetic-shifted right 1.
    - It is computed in the publish cycle, so latency is unchanged.
  - Undefined: channels pass through unmodified.

## Test plan
- Nominal frame, SCLK = clock/16, 32-bit slots, left=16'h8001, right=16'h7FFE, `sample_ready`=1 → one `sample_valid` pulse, `sample_left`=16'h8001, `sample_right`=16'h7FFE, no `frame_err`/`overrun`.
- Reset released with `lrck`=1 mid right slot → no output until after a full left+right frame; first pair matches the transmitted values.
- Left slot shortened to 28 edges → `frame_err` pulses once; that frame's pair is not published; the next frame is published correctly.
- `sample_ready`=0 across two frames (A=1111/2222, B=3333/4444) → `overrun` pulses once at B's publish; outputs show 16'h3333/16'h4444; raising `sample_ready` clears `sample_valid` next cycle.
- Publish coincides with `sample_ready`=1 → `sample_valid` stays 1 with the new pair, `overrun`=0.
- With `I2S_RX_MONO_SUM_EN`, left=16'h7FFF, right=16'h0001 → both outputs 16'h4000; left=16'h8000, right=16'h8000 → both 16'h8000.
